// File: rtl/rob_pkg.sv
// rtl/rob_pkg.sv - shared widths, retire-entry layout and retire FSM encodings
package rob_pkg;

  localparam int TAG_W  = 5;
  localparam int REG_W  = 5;
  localparam int DATA_W = 32;

  typedef struct packed {
    logic [TAG_W-1:0]  tag;
    logic [REG_W-1:0]  rd_reg;
    logic [DATA_W-1:0] data;
    logic [DATA_W-1:0] pc;
    logic              branch;
    logic              taken;
    logic              store;
  } retire_entry_t;

  localparam int ENTRY_W = $bits(retire_entry_t);

  typedef enum logic [1:0] {
    ST_IDLE       = 2'd0,
    ST_STORE_WAIT = 2'd1,
    ST_FLUSH      = 2'd2
  } rc_state_t;

endpackage

// File: rtl/retire_fifo.sv
// rtl/retire_fifo.sv - parameterised sync FIFO with clear, occupancy count and full/empty
module retire_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 8
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     push,
  input  logic                     pop,
  input  logic                     clear,
  input  logic [W-1:0]             wdata,
  output logic [W-1:0]             rdata,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [W-1:0]     mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == CNT_W'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign rdata   = mem[rd_ptr];

  always_ff @(posedge clock) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

  // Clear wins over a same-cycle push: anything arriving with a redirect is younger and squashed.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      unique case ({do_push, do_pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/retire_commit.sv
// rtl/retire_commit.sv - retire stage: regfile commit, store handoff, redirect/flush, tag return
// Optional RETIRE_STATS_EN adds saturating Stat_retired / Stat_mispredict counters.
module retire_commit
  import rob_pkg::*;
#(
  parameter int FIFO_DEPTH   = 4,
  parameter int FLUSH_CYCLES = 2
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              Retire_valid,
  input  logic [TAG_W-1:0]  Retire_rd_tag,
  input  logic [REG_W-1:0]  Retire_rd_reg,
  input  logic [DATA_W-1:0] Retire_data,
  input  logic [DATA_W-1:0] Retire_pc,
  input  logic              Retire_branch,
  input  logic              Retire_branch_taken,
  input  logic              Retire_store_ready,
  output logic              Retire_stall,
  output logic              Rf_wen,
  output logic [REG_W-1:0]  Rf_waddr,
  output logic [DATA_W-1:0] Rf_wdata,
  output logic              Store_commit_req,
  output logic [TAG_W-1:0]  Store_commit_tag,
  input  logic              Store_commit_ack,
  output logic              Redirect_valid,
  output logic [DATA_W-1:0] Redirect_pc,
  output logic              Flush_out,
  output logic              Tag_free_valid,
  output logic [TAG_W-1:0]  Tag_free,
  output logic              Overflow_err
`ifdef RETIRE_STATS_EN
  ,
  output logic [31:0]       Stat_retired,
  output logic [15:0]       Stat_mispredict
`endif
);

  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
  localparam int FC_W  = $clog2(FLUSH_CYCLES + 1);

  retire_entry_t     push_entry;
  retire_entry_t     head;
  logic [ENTRY_W-1:0] fifo_rdata;
  logic [CNT_W-1:0]  fifo_count;
  logic              fifo_full;
  logic              fifo_empty;
  logic              push_en;
  logic              pop;
  logic              clr;

  rc_state_t         state_q, state_d;
  logic [FC_W-1:0]   flush_cnt_q, flush_cnt_d;
  logic              rf_wen_q, rf_wen_d;
  logic [REG_W-1:0]  rf_waddr_q, rf_waddr_d;
  logic [DATA_W-1:0] rf_wdata_q, rf_wdata_d;
  logic              req_q, req_d;
  logic [TAG_W-1:0]  stag_q, stag_d;
  logic              redir_v_q, redir_v_d;
  logic [DATA_W-1:0] redir_pc_q, redir_pc_d;
  logic              flush_q, flush_d;
  logic              tfree_v_q, tfree_v_d;
  logic [TAG_W-1:0]  tfree_q, tfree_d;
  logic              ovf_q;

  assign push_entry = '{tag: Retire_rd_tag, rd_reg: Retire_rd_reg, data: Retire_data,
                        pc: Retire_pc, branch: Retire_branch, taken: Retire_branch_taken,
                        store: Retire_store_ready};
  assign push_en    = Retire_valid & ~fifo_full & ~flush_q;
  assign head       = fifo_rdata;

  retire_fifo #(.DEPTH(FIFO_DEPTH), .W(ENTRY_W)) u_fifo (
    .clock (clock),
    .reset (reset),
    .push  (push_en),
    .pop   (pop),
    .clear (clr),
    .wdata (push_entry),
    .rdata (fifo_rdata),
    .count (fifo_count),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  always_comb begin
    state_d     = state_q;
    flush_cnt_d = flush_cnt_q;
    rf_wen_d    = 1'b0;
    rf_waddr_d  = rf_waddr_q;
    rf_wdata_d  = rf_wdata_q;
    req_d       = req_q;
    stag_d      = stag_q;
    redir_v_d   = 1'b0;
    redir_pc_d  = redir_pc_q;
    flush_d     = flush_q;
    tfree_v_d   = 1'b0;
    tfree_d     = tfree_q;
    pop         = 1'b0;
    clr         = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (!fifo_empty) begin
          pop = 1'b1;
          if (head.store) begin
            req_d   = 1'b1;
            stag_d  = head.tag;
            state_d = ST_STORE_WAIT;
          end else if (head.branch && head.taken) begin
            redir_v_d   = 1'b1;
            redir_pc_d  = head.pc;
            flush_d     = 1'b1;
            flush_cnt_d = FC_W'(FLUSH_CYCLES - 1);
            tfree_v_d   = 1'b1;
            tfree_d     = head.tag;
            clr         = 1'b1;
            state_d     = ST_FLUSH;
          end else if (head.branch) begin
            tfree_v_d = 1'b1;
            tfree_d   = head.tag;
          end else begin
            // x0 is hardwired; the tag is still returned so the ROB slot recycles.
            rf_wen_d   = (head.rd_reg != '0);
            rf_waddr_d = head.rd_reg;
            rf_wdata_d = head.data;
            tfree_v_d  = 1'b1;
            tfree_d    = head.tag;
          end
        end
      end
      ST_STORE_WAIT: begin
        if (Store_commit_ack) begin
          req_d     = 1'b0;
          tfree_v_d = 1'b1;
          tfree_d   = stag_q;
          state_d   = ST_IDLE;
        end
      end
      ST_FLUSH: begin
        if (flush_cnt_q == '0) begin
          flush_d = 1'b0;
          state_d = ST_IDLE;
        end else begin
          flush_cnt_d = flush_cnt_q - FC_W'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q     <= ST_IDLE;
      flush_cnt_q <= '0;
      rf_wen_q    <= 1'b0;
      rf_waddr_q  <= '0;
      rf_wdata_q  <= '0;
      req_q       <= 1'b0;
      stag_q      <= '0;
      redir_v_q   <= 1'b0;
      redir_pc_q  <= '0;
      flush_q     <= 1'b0;
      tfree_v_q   <= 1'b0;
      tfree_q     <= '0;
      ovf_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      flush_cnt_q <= flush_cnt_d;
      rf_wen_q    <= rf_wen_d;
      rf_waddr_q  <= rf_waddr_d;
      rf_wdata_q  <= rf_wdata_d;
      req_q       <= req_d;
      stag_q      <= stag_d;
      redir_v_q   <= redir_v_d;
      redir_pc_q  <= redir_pc_d;
      flush_q     <= flush_d;
      tfree_v_q   <= tfree_v_d;
      tfree_q     <= tfree_d;
      ovf_q       <= ovf_q | (Retire_valid & fifo_full);
    end
  end

  assign Retire_stall     = (fifo_count >= CNT_W'(FIFO_DEPTH - 1));
  assign Rf_wen           = rf_wen_q;
  assign Rf_waddr         = rf_waddr_q;
  assign Rf_wdata         = rf_wdata_q;
  assign Store_commit_req = req_q;
  assign Store_commit_tag = stag_q;
  assign Redirect_valid   = redir_v_q;
  assign Redirect_pc      = redir_pc_q;
  assign Flush_out        = flush_q;
  assign Tag_free_valid   = tfree_v_q;
  assign Tag_free         = tfree_q;
  assign Overflow_err     = ovf_q;

`ifdef RETIRE_STATS_EN
  logic [31:0] stat_ret_q;
  logic [15:0] stat_mis_q;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      stat_ret_q <= '0;
      stat_mis_q <= '0;
    end else begin
      if (tfree_v_q && (stat_ret_q != '1)) stat_ret_q <= stat_ret_q + 32'd1;
      if (redir_v_q && (stat_mis_q != '1)) stat_mis_q <= stat_mis_q + 16'd1;
    end
  end

  assign Stat_retired    = stat_ret_q;
  assign Stat_mispredict = stat_mis_q;
`endif

endmodule
